// File: rtl/global_defs_pkg.sv
// rtl/global_defs_pkg.sv - shared types, opcode encodings and age helper for the integer execute slice
`ifndef ROB_ID_WIDTH
`define ROB_ID_WIDTH 5
`endif

package global_defs;

  localparam int XLEN         = 32;
  localparam int ROB_ID_WIDTH = `ROB_ID_WIDTH;

  typedef logic [XLEN-1:0]         reg_data_t;
  typedef logic [ROB_ID_WIDTH-1:0] rob_id_t;

  // ALU funct3 encodings
  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  // Branch funct3 encodings
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef struct packed {
    reg_data_t  src1;
    reg_data_t  src2;
    reg_data_t  imm;
    reg_data_t  pc;
    rob_id_t    rob_id;
    logic [2:0] funct3;
    logic       is_r_type;
    logic       is_sub;
    logic       is_sra_srai;
    logic       is_lui;
    logic       is_auipc;
    logic       is_jal;
    logic       is_jalr;
    logic       is_branch;
    logic       br_dir_pred;
    reg_data_t  br_target_pred;
  } iiq_issue_data_t;

  localparam int IIQ_ISSUE_DATA_WIDTH = $bits(iiq_issue_data_t);

  typedef enum logic [1:0] {
    REDIR_IDLE,
    REDIR_HOLD,
    REDIR_SHADOW
  } exec_redir_state_t;

  // Distance from the ROB head; wraps naturally in the tag width so tags
  // on either side of the wrap point order correctly.
  function automatic rob_id_t rob_age(input rob_id_t tag, input rob_id_t head);
    return tag - head;
  endfunction

endpackage

// File: rtl/integer_execute_alu.sv
// rtl/integer_execute_alu.sv - combinational ALU, branch resolution and mispredict detection
module int_alu
  import global_defs::*;
(
  input  logic [IIQ_ISSUE_DATA_WIDTH-1:0] issue_data,
  output logic [XLEN-1:0]                 result,
  output logic                            actual_taken,
  output logic [XLEN-1:0]                 target,
  output logic                            mispred
);

  iiq_issue_data_t d;
  reg_data_t       op2;
  reg_data_t       alu_res;
  reg_data_t       pc_plus4;
  logic [4:0]      shamt;
  logic            cmp_taken;
  logic            is_ctrl;

  // Decode, compute the ALU result and resolve control flow in one pass
  always_comb begin
    d        = iiq_issue_data_t'(issue_data);
    op2      = d.is_r_type ? d.src2 : d.imm;
    shamt    = op2[4:0];
    pc_plus4 = d.pc + reg_data_t'(4);

    alu_res = '0;
    case (d.funct3)
      F3_ADD:  alu_res = (d.is_r_type && d.is_sub) ? (d.src1 - op2) : (d.src1 + op2);
      F3_SLL:  alu_res = d.src1 << shamt;
      F3_SLT:  alu_res = {{(XLEN-1){1'b0}}, $signed(d.src1) < $signed(op2)};
      F3_SLTU: alu_res = {{(XLEN-1){1'b0}}, d.src1 < op2};
      F3_XOR:  alu_res = d.src1 ^ op2;
      F3_SR:   alu_res = d.is_sra_srai ? reg_data_t'($signed(d.src1) >>> shamt)
                                       : (d.src1 >> shamt);
      F3_OR:   alu_res = d.src1 | op2;
      F3_AND:  alu_res = d.src1 & op2;
      default: alu_res = '0;
    endcase

    cmp_taken = 1'b0;
    case (d.funct3)
      F3_BEQ:  cmp_taken = (d.src1 == d.src2);
      F3_BNE:  cmp_taken = (d.src1 != d.src2);
      F3_BLT:  cmp_taken = ($signed(d.src1) <  $signed(d.src2));
      F3_BGE:  cmp_taken = ($signed(d.src1) >= $signed(d.src2));
      F3_BLTU: cmp_taken = (d.src1 <  d.src2);
      F3_BGEU: cmp_taken = (d.src1 >= d.src2);
      default: cmp_taken = 1'b0;
    endcase

    is_ctrl = d.is_jal | d.is_jalr | d.is_branch;

    // jalr drops bit 0 of the computed address
    target = d.is_jalr ? ((d.src1 + d.imm) & ~reg_data_t'(1)) : (d.pc + d.imm);

    actual_taken = d.is_branch ? cmp_taken : (d.is_jal | d.is_jalr);

    if (d.is_lui)                  result = d.imm;
    else if (d.is_auipc)           result = d.pc + d.imm;
    else if (d.is_jal || d.is_jalr) result = pc_plus4;
    else if (d.is_branch)          result = '0;
    else                           result = alu_res;

    mispred = is_ctrl & ((actual_taken != d.br_dir_pred) |
                         (actual_taken & (target != d.br_target_pred)));
  end

endmodule

// File: rtl/integer_execute.sv
// rtl/integer_execute.sv - execute stage: completion broadcast and oldest-mispredict redirect FSM
module integer_execute #(
  parameter int XLEN         = global_defs::XLEN,
  parameter int ROB_ID_WIDTH = global_defs::ROB_ID_WIDTH
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic                                         issue_valid,
  input  logic [global_defs::IIQ_ISSUE_DATA_WIDTH-1:0] issue_data,
  input  logic [ROB_ID_WIDTH-1:0]                      rob_head_id,
  input  logic                                         flush,
  output logic                                         alu_broadcast_valid,
  output logic [ROB_ID_WIDTH-1:0]                      alu_broadcast_rob_id,
  output logic [XLEN-1:0]                              alu_broadcast_reg_data,
  output logic                                         alu_broadcast_mispred,
  output logic                                         redirect_valid,
  input  logic                                         redirect_ready,
  output logic [XLEN-1:0]                              redirect_pc,
  output logic [ROB_ID_WIDTH-1:0]                      redirect_rob_id
);

  import global_defs::*;

  iiq_issue_data_t   d;
  reg_data_t         alu_result;
  reg_data_t         alu_target;
  logic              alu_taken;
  logic              alu_mispred;
  reg_data_t         correct_pc;
  logic              new_mispred;
  logic              older_than_held;
  logic              older_than_shadow;
  exec_redir_state_t state;
  rob_id_t           shadow_id;

  assign d = iiq_issue_data_t'(issue_data);

  int_alu u_alu (
    .issue_data   (issue_data),
    .result       (alu_result),
    .actual_taken (alu_taken),
    .target       (alu_target),
    .mispred      (alu_mispred)
  );

  // Correct next PC and relative age of the incoming mispredict
  always_comb begin
    correct_pc        = alu_taken ? alu_target : (d.pc + reg_data_t'(4));
    new_mispred       = issue_valid & alu_mispred;
    older_than_held   = rob_age(d.rob_id, rob_head_id) < rob_age(redirect_rob_id, rob_head_id);
    older_than_shadow = rob_age(d.rob_id, rob_head_id) < rob_age(shadow_id, rob_head_id);
  end

  // One-cycle completion broadcast; flush discards the op issued that cycle
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      alu_broadcast_valid    <= 1'b0;
      alu_broadcast_rob_id   <= '0;
      alu_broadcast_reg_data <= '0;
      alu_broadcast_mispred  <= 1'b0;
    end else begin
      alu_broadcast_valid    <= issue_valid;
      alu_broadcast_rob_id   <= d.rob_id;
      alu_broadcast_reg_data <= alu_result;
      alu_broadcast_mispred  <= new_mispred;
    end
  end

  // Redirect FSM: hold the oldest mispredict until the frontend takes it,
  // then shadow it so younger wrong-path mispredicts cannot redirect again
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      state           <= REDIR_IDLE;
      redirect_valid  <= 1'b0;
      redirect_pc     <= '0;
      redirect_rob_id <= '0;
      shadow_id       <= '0;
    end else begin
      case (state)
        REDIR_IDLE: begin
          if (new_mispred) begin
            state           <= REDIR_HOLD;
            redirect_valid  <= 1'b1;
            redirect_pc     <= correct_pc;
            redirect_rob_id <= d.rob_id;
          end
        end
        REDIR_HOLD: begin
          // An older mispredict supersedes the held one whether or not it is accepted now
          if (new_mispred && older_than_held) begin
            redirect_valid  <= 1'b1;
            redirect_pc     <= correct_pc;
            redirect_rob_id <= d.rob_id;
          end else if (redirect_ready) begin
            state          <= REDIR_SHADOW;
            redirect_valid <= 1'b0;
            shadow_id      <= redirect_rob_id;
          end
        end
        REDIR_SHADOW: begin
          if (new_mispred && older_than_shadow) begin
            state           <= REDIR_HOLD;
            redirect_valid  <= 1'b1;
            redirect_pc     <= correct_pc;
            redirect_rob_id <= d.rob_id;
          end
        end
        default: begin
          state          <= REDIR_IDLE;
          redirect_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_integer_execute.sv
// tb/tb_integer_execute.sv - directed self-checking bench for integer_execute
module tb_integer_execute;
  import global_defs::*;

  logic                            clk;
  logic                            rst;
  logic                            issue_valid;
  iiq_issue_data_t                 d;
  logic [IIQ_ISSUE_DATA_WIDTH-1:0] issue_data;
  logic [ROB_ID_WIDTH-1:0]         rob_head_id;
  logic                            flush;
  logic                            bv;
  logic [ROB_ID_WIDTH-1:0]         btag;
  logic [XLEN-1:0]                 bdata;
  logic                            bmis;
  logic                            rv;
  logic                            redirect_ready;
  logic [XLEN-1:0]                 rpc;
  logic [ROB_ID_WIDTH-1:0]         rid;

  int checks = 0;
  int errors = 0;

  assign issue_data = d;

  integer_execute dut (
    .clk                    (clk),
    .rst                    (rst),
    .issue_valid            (issue_valid),
    .issue_data             (issue_data),
    .rob_head_id            (rob_head_id),
    .flush                  (flush),
    .alu_broadcast_valid    (bv),
    .alu_broadcast_rob_id   (btag),
    .alu_broadcast_reg_data (bdata),
    .alu_broadcast_mispred  (bmis),
    .redirect_valid         (rv),
    .redirect_ready         (redirect_ready),
    .redirect_pc            (rpc),
    .redirect_rob_id        (rid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic issue_one();
    issue_valid = 1'b1;
    cycle();
    issue_valid = 1'b0;
  endtask

  task automatic alu_op(input string tag, input logic [2:0] f3, input logic r, input logic sub,
                        input logic sra, input logic [31:0] s1, input logic [31:0] s2,
                        input logic [31:0] imm, input logic [31:0] exp);
    d = '0;
    d.funct3 = f3; d.is_r_type = r; d.is_sub = sub; d.is_sra_srai = sra;
    d.src1 = s1; d.src2 = s2; d.imm = imm; d.rob_id = 5'd7;
    issue_one();
    check({tag, "_valid"}, 64'(bv), 64'd1);
    check({tag, "_data"}, 64'(bdata), 64'(exp));
  endtask

  task automatic branch_op(input logic [2:0] f3, input logic [31:0] s1, input logic [31:0] s2,
                           input logic [31:0] pc, input logic [31:0] imm, input logic pred,
                           input logic [31:0] pred_tgt, input logic [4:0] tag);
    d = '0;
    d.is_branch = 1'b1; d.funct3 = f3; d.src1 = s1; d.src2 = s2;
    d.pc = pc; d.imm = imm; d.br_dir_pred = pred; d.br_target_pred = pred_tgt; d.rob_id = tag;
    issue_one();
  endtask

  initial begin
    rst = 1'b1; issue_valid = 1'b0; d = '0; rob_head_id = '0; flush = 1'b0; redirect_ready = 1'b0;
    cycle(); cycle();
    check("rst_bv", 64'(bv), 64'd0);
    check("rst_rv", 64'(rv), 64'd0);
    check("rst_bdata", 64'(bdata), 64'd0);
    check("rst_rpc", 64'(rpc), 64'd0);
    rst = 1'b0;
    cycle();
    check("idle_bv", 64'(bv), 64'd0);

    // add with one-cycle latency and single-cycle valid
    d = '0; d.src1 = 32'd5; d.src2 = 32'd7; d.is_r_type = 1'b1; d.rob_id = 5'd3;
    issue_one();
    check("add_valid", 64'(bv), 64'd1);
    check("add_tag", 64'(btag), 64'd3);
    check("add_data", 64'(bdata), 64'd12);
    check("add_mis", 64'(bmis), 64'd0);
    cycle();
    check("add_valid_gone", 64'(bv), 64'd0);

    alu_op("sub",  3'b000, 1, 1, 0, 32'd0,        32'd1,        32'd0,  32'hFFFF_FFFF);
    alu_op("sra",  3'b101, 0, 0, 1, 32'h8000_0000, 32'd0,       32'd4,  32'hF800_0000);
    alu_op("srl",  3'b101, 0, 0, 0, 32'h8000_0000, 32'd0,       32'd4,  32'h0800_0000);
    alu_op("sltu", 3'b011, 1, 0, 0, 32'd1,        32'hFFFF_FFFF, 32'd0, 32'd1);
    alu_op("slt",  3'b010, 1, 0, 0, 32'd1,        32'hFFFF_FFFF, 32'd0, 32'd0);
    alu_op("slli", 3'b001, 0, 0, 0, 32'd1,        32'd0,        32'd31, 32'h8000_0000);
    alu_op("xor",  3'b100, 1, 0, 0, 32'hF0F0,     32'h0FF0,     32'd0,  32'hFF00);
    alu_op("or",   3'b110, 1, 0, 0, 32'hF000,     32'h000F,     32'd0,  32'hF00F);
    alu_op("and",  3'b111, 1, 0, 0, 32'hFF00,     32'h0FF0,     32'd0,  32'h0F00);
    alu_op("addi_sub_ignored", 3'b000, 0, 1, 0, 32'd10, 32'd99, 32'd3, 32'd13);

    d = '0; d.is_lui = 1'b1; d.imm = 32'h1234_5000;
    issue_one();
    check("lui", 64'(bdata), 64'h1234_5000);
    d = '0; d.is_auipc = 1'b1; d.pc = 32'h1000; d.imm = 32'h2000;
    issue_one();
    check("auipc", 64'(bdata), 64'h3000);

    // beq taken, predicted not-taken: held until accepted
    branch_op(3'b000, 32'd9, 32'd9, 32'h100, 32'h20, 1'b0, 32'h0, 5'd2);
    check("beq_bdata", 64'(bdata), 64'd0);
    check("beq_bmis", 64'(bmis), 64'd1);
    check("beq_rv", 64'(rv), 64'd1);
    check("beq_rpc", 64'(rpc), 64'h120);
    check("beq_rid", 64'(rid), 64'd2);
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("hold_rv", 64'(rv), 64'd1);
      check("hold_rpc", 64'(rpc), 64'h120);
    end
    redirect_ready = 1'b1; cycle(); redirect_ready = 1'b0;
    check("accept_rv", 64'(rv), 64'd0);

    // head 4: tag 6 older than shadow 2, then tag 5 replaces, tag 9 dropped
    rob_head_id = 5'd4;
    branch_op(3'b000, 32'd1, 32'd1, 32'h300, 32'h8, 1'b0, 32'h0, 5'd6);
    check("t6_rv", 64'(rv), 64'd1);
    check("t6_rpc", 64'(rpc), 64'h308);
    branch_op(3'b001, 32'd1, 32'd2, 32'h200, 32'h40, 1'b0, 32'h0, 5'd5);
    check("t5_rpc", 64'(rpc), 64'h240);
    check("t5_rid", 64'(rid), 64'd5);
    branch_op(3'b100, 32'hFFFF_FFFF, 32'd1, 32'h400, 32'h10, 1'b0, 32'h0, 5'd9);
    check("t9_bmis", 64'(bmis), 64'd1);
    check("t9_rpc", 64'(rpc), 64'h240);
    check("t9_rid", 64'(rid), 64'd5);
    branch_op(3'b101, 32'hFFFF_FFFF, 32'd1, 32'h440, 32'h10, 1'b0, 32'h0, 5'd10);
    check("bge_nt_bmis", 64'(bmis), 64'd0);
    redirect_ready = 1'b1; cycle(); redirect_ready = 1'b0;
    check("accept5_rv", 64'(rv), 64'd0);

    // wrap: head 30, tag 1 (age 3) from shadow 5 (age 7), then tag 31 (age 1) replaces
    rob_head_id = 5'd30;
    branch_op(3'b111, 32'd1, 32'd2, 32'h500, 32'hC, 1'b1, 32'h50C, 5'd1);
    check("bgeu_rv", 64'(rv), 64'd1);
    check("bgeu_rpc_fallthru", 64'(rpc), 64'h504);
    check("bgeu_rid", 64'(rid), 64'd1);
    d = '0; d.is_jal = 1'b1; d.pc = 32'h600; d.imm = 32'h100; d.br_dir_pred = 1'b1;
    d.br_target_pred = 32'h0; d.rob_id = 5'd31;
    issue_one();
    check("jal_bdata", 64'(bdata), 64'h604);
    check("jal_bmis", 64'(bmis), 64'd1);
    check("wrap_rpc", 64'(rpc), 64'h700);
    check("wrap_rid", 64'(rid), 64'd31);

    // flush during HOLD with a concurrent issue
    d = '0; d.is_jalr = 1'b1; d.src1 = 32'h40; d.rob_id = 5'd3;
    issue_valid = 1'b1; flush = 1'b1;
    cycle();
    issue_valid = 1'b0; flush = 1'b0;
    check("flush_bv", 64'(bv), 64'd0);
    check("flush_rv", 64'(rv), 64'd0);
    cycle();
    check("flush_idle_rv", 64'(rv), 64'd0);

    // jalr target bit 0 cleared; then shadow 2 blocks younger 3, admits older 1
    d = '0; d.is_jalr = 1'b1; d.src1 = 32'h1001; d.imm = 32'h10; d.pc = 32'h700;
    d.br_dir_pred = 1'b1; d.br_target_pred = 32'h0; d.rob_id = 5'd2;
    issue_one();
    check("jalr_bdata", 64'(bdata), 64'h704);
    check("jalr_rpc", 64'(rpc), 64'h1010);
    check("jalr_rv", 64'(rv), 64'd1);
    redirect_ready = 1'b1; cycle(); redirect_ready = 1'b0;
    check("accept2_rv", 64'(rv), 64'd0);
    branch_op(3'b000, 32'd0, 32'd0, 32'h800, 32'h4, 1'b0, 32'h0, 5'd3);
    check("shadow_drop_bmis", 64'(bmis), 64'd1);
    check("shadow_drop_rv", 64'(rv), 64'd0);
    branch_op(3'b000, 32'd0, 32'd0, 32'h900, 32'h8, 1'b0, 32'h0, 5'd1);
    check("shadow_older_rv", 64'(rv), 64'd1);
    check("shadow_older_rpc", 64'(rpc), 64'h908);

    // accept and older mispredict in the same cycle
    redirect_ready = 1'b1;
    branch_op(3'b000, 32'd0, 32'd0, 32'hA00, 32'h8, 1'b0, 32'h0, 5'd31);
    redirect_ready = 1'b0;
    check("rdy_older_rv", 64'(rv), 64'd1);
    check("rdy_older_rpc", 64'(rpc), 64'hA08);
    check("rdy_older_rid", 64'(rid), 64'd31);

    // reset while holding
    rst = 1'b1;
    cycle();
    check("rst_hold_rv", 64'(rv), 64'd0);
    check("rst_hold_rpc", 64'(rpc), 64'd0);
    rst = 1'b0;
    cycle();
    check("post_rst_rv", 64'(rv), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
